// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// arbitration state encoding and read-owner tag values.
package mem_arb_pkg;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_LOCKED0 = 2'd1,
        ST_LOCKED1 = 2'd2
    } arb_state_e;

    localparam logic OWNER_0 = 1'b0;
    localparam logic OWNER_1 = 1'b1;

    // Requester that should win the next contended cycle after owner is served
    function automatic logic other_owner(input logic owner);
        return ~owner;
    endfunction

endpackage

// File: rtl/mem_arbiter_2p_if.sv
// Requester-side bundle of the two-port memory arbiter. The master modport
// is the pair of requesters; the slave modport is the arbiter.
interface mem_arbiter_2p_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          lock0;
    logic          lock1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );

endinterface

// File: rtl/mem_arbiter_2p_rd_tag_pipe.sv
// Read-return tracker: an RD_LAT-deep shift register carrying a valid bit and
// the owner of each granted read, so the tag pops out in the cycle the RAM
// presents that read's data. Async clear drops all in-flight reads.
module rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid_i,
    input  logic push_owner_i,
    output logic pop_valid_o,
    output logic pop_owner_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] owner_q;

    // Shift valid/owner tags one stage per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1];
                owner_q[i] <= owner_q[i-1];
            end
            valid_q[0] <= push_valid_i;
            owner_q[0] <= push_owner_i;
        end
    end

    assign pop_valid_o = valid_q[RD_LAT-1];
    assign pop_owner_o = owner_q[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter_2p.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM,
// with optional bounded lock for back-to-back exclusive ownership.
module mem_arbiter_2p
    import mem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic               clock,
    input  logic               resetn,
    mem_arbiter_2p_if.slave    bus,
    output logic [AW-1:0]      mem_address,
    output logic [DW-1:0]      mem_data,
    output logic               mem_wren,
    input  logic [DW-1:0]      mem_q
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e    state_q, state_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    logic          gnt0_s, gnt1_s;
    logic          gnt_any_s;
    logic          owner_s;
    logic          lock_sel_s;
    logic [CW-1:0] cnt_next_s;
    logic          pop_valid_s;
    logic          pop_owner_s;

    // Grant selection, lock tracking and round-robin pointer update
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        case (state_q)
            ST_FREE: begin
                if (bus.req0 && bus.req1) begin
                    if (rr_q == OWNER_1) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b1;
                    end
                end else if (bus.req0) begin
                    gnt0_s = 1'b1;
                end else if (bus.req1) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                end
            end
            ST_LOCKED0: gnt0_s = bus.req0;
            ST_LOCKED1: gnt1_s = bus.req1;
            default:    state_d = ST_FREE;
        endcase
        // No grant can be issued while the arbiter is held in reset
        gnt0_s     = gnt0_s & resetn;
        gnt1_s     = gnt1_s & resetn;
        gnt_any_s  = gnt0_s | gnt1_s;
        owner_s    = gnt1_s ? OWNER_1 : OWNER_0;
        lock_sel_s = gnt1_s ? bus.lock1 : bus.lock0;
        // The grant that enters a lock counts as the first locked grant
        cnt_next_s = (state_q == ST_FREE) ? CW'(1) : (cnt_q + CW'(1));
        if (gnt_any_s) begin
            rr_d = other_owner(owner_s);
            if (lock_sel_s && (cnt_next_s < CW'(LOCK_MAX))) begin
                state_d = (owner_s == OWNER_1) ? ST_LOCKED1 : ST_LOCKED0;
                cnt_d   = cnt_next_s;
            end else begin
                state_d = ST_FREE;
                cnt_d   = '0;
            end
        end else if (state_q != ST_FREE) begin
            // Owner dropped its request while locked: release
            state_d = ST_FREE;
            cnt_d   = '0;
        end else begin
            cnt_d = '0;
        end
    end

    // Arbitration state, pointer and lock counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_FREE;
            rr_q    <= OWNER_0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Steer the granted requester onto the RAM bus, else replay the last values
    always_comb begin
        mem_address = addr_q;
        mem_data    = data_q;
        mem_wren    = 1'b0;
        if (gnt0_s) begin
            mem_address = bus.addr0;
            mem_data    = bus.wdata0;
            mem_wren    = bus.we0;
        end else if (gnt1_s) begin
            mem_address = bus.addr1;
            mem_data    = bus.wdata1;
            mem_wren    = bus.we1;
        end else begin
            mem_wren    = 1'b0;
        end
    end

    // Hold copy of the last address/data driven to the RAM
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            data_q <= '0;
        end else if (gnt_any_s) begin
            addr_q <= mem_address;
            data_q <= mem_data;
        end else begin
            addr_q <= addr_q;
            data_q <= data_q;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk          (clock),
        .rst_n        (resetn),
        .push_valid_i (gnt_any_s & ~mem_wren),
        .push_owner_i (owner_s),
        .pop_valid_o  (pop_valid_s),
        .pop_owner_o  (pop_owner_s)
    );

    // Route returning read data to its owner; mem_q is already the RAM's
    // registered output, so it is presented in the cycle the tag pops out
    always_comb begin
        bus.rvalid0 = pop_valid_s & (pop_owner_s == OWNER_0);
        bus.rvalid1 = pop_valid_s & (pop_owner_s == OWNER_1);
        bus.rdata0  = '0;
        bus.rdata1  = '0;
        if (bus.rvalid0) begin
            bus.rdata0 = mem_q;
        end else if (bus.rvalid1) begin
            bus.rdata1 = mem_q;
        end else begin
            bus.rdata0 = '0;
        end
    end

    assign bus.gnt0 = gnt0_s;
    assign bus.gnt1 = gnt1_s;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed self-checking bench for mem_arbiter_2p with a behavioural
// single-port RAM (one-clock registered read).
module tb_mem_arbiter_2p;

    logic        clock;
    logic        resetn;
    logic [5:0]  mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;
    logic [15:0] ram [0:63];
    int          pass_cnt;
    int          chk_cnt;

    mem_arbiter_2p_if #(.AW(6), .DW(16)) bus ();

    mem_arbiter_2p #(.AW(6), .DW(16), .RD_LAT(1), .LOCK_MAX(8)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    always #5 clock = ~clock;

    // Synchronous RAM model: write on wren, q registered from the address
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.lock0 = 1'b0; bus.lock1 = 1'b0;
    endtask

    task automatic test_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd7; bus.wdata0 = 16'hBEEF;
        #2;
        chk_cnt++; if (bus.gnt0 !== 1'b0) $display("FAIL rst_gnt0 got %b exp 0", bus.gnt0); else pass_cnt++;
        chk_cnt++; if (bus.gnt1 !== 1'b0) $display("FAIL rst_gnt1 got %b exp 0", bus.gnt1); else pass_cnt++;
        chk_cnt++; if (mem_wren !== 1'b0) $display("FAIL rst_wren got %b exp 0", mem_wren); else pass_cnt++;
        chk_cnt++; if (mem_address !== 6'd0) $display("FAIL rst_addr got %h exp 0", mem_address); else pass_cnt++;
        chk_cnt++; if (mem_data !== 16'h0000) $display("FAIL rst_data got %h exp 0", mem_data); else pass_cnt++;
        chk_cnt++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) $display("FAIL rst_rvalid got %b exp 00", {bus.rvalid0, bus.rvalid1}); else pass_cnt++;
        chk_cnt++; if ({bus.rdata0, bus.rdata1} !== 32'h0) $display("FAIL rst_rdata got %h exp 0", {bus.rdata0, bus.rdata1}); else pass_cnt++;
        idle_all();
        @(negedge clock);
        resetn = 1'b1;
        next_cycle();
    endtask

    // Fill RAM through requester 1 alone
    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = a; bus.wdata1 = d;
        @(negedge clock);
        chk_cnt++; if (bus.gnt1 !== 1'b1 || mem_wren !== 1'b1) $display("FAIL preload_gnt a=%0d got gnt1=%b wren=%b exp 1 1", a, bus.gnt1, mem_wren); else pass_cnt++;
        next_cycle();
        idle_all();
    endtask

    task automatic test_single(input logic [5:0] a, input logic [15:0] d);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = a; bus.wdata0 = d;
        @(negedge clock);
        chk_cnt++; if (bus.gnt0 !== 1'b1) $display("FAIL single_wr_gnt0 got %b exp 1", bus.gnt0); else pass_cnt++;
        chk_cnt++; if (mem_wren !== 1'b1 || mem_address !== a || mem_data !== d) $display("FAIL single_wr_bus got %b %h %h exp 1 %h %h", mem_wren, mem_address, mem_data, a, d); else pass_cnt++;
        next_cycle();
        bus.we0 = 1'b0; bus.wdata0 = 16'h0000;
        @(negedge clock);
        chk_cnt++; if (bus.gnt0 !== 1'b1 || mem_wren !== 1'b0) $display("FAIL single_rd_gnt got gnt0=%b wren=%b exp 1 0", bus.gnt0, mem_wren); else pass_cnt++;
        chk_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL single_rd_early got %b exp 0", bus.rvalid0); else pass_cnt++;
        next_cycle();
        idle_all();
        @(negedge clock);
        chk_cnt++; if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0) $display("FAIL single_rvalid got %b%b exp 10", bus.rvalid0, bus.rvalid1); else pass_cnt++;
        chk_cnt++; if (bus.rdata0 !== d) $display("FAIL single_rdata got %h exp %h", bus.rdata0, d); else pass_cnt++;
        chk_cnt++; if (bus.gnt0 !== 1'b0 || mem_wren !== 1'b0 || mem_address !== a || mem_data !== 16'h0000) $display("FAIL single_hold got %b %b %h %h exp 0 0 %h 0000", bus.gnt0, mem_wren, mem_address, mem_data, a); else pass_cnt++;
        next_cycle();
        @(negedge clock);
        chk_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL single_rvalid_pulse got %b exp 0", bus.rvalid0); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd5;
        @(negedge clock);
        chk_cnt++; if (bus.gnt0 !== 1'b1) $display("FAIL midrst_gnt0 got %b exp 1", bus.gnt0); else pass_cnt++;
        #2;
        resetn = 1'b0;
        bus.req0 = 1'b0;
        #1;
        chk_cnt++; if ({bus.gnt0, bus.gnt1, mem_wren, bus.rvalid0, bus.rvalid1} !== 5'b0) $display("FAIL midrst_ctrl got %b exp 00000", {bus.gnt0, bus.gnt1, mem_wren, bus.rvalid0, bus.rvalid1}); else pass_cnt++;
        chk_cnt++; if (mem_address !== 6'd0 || mem_data !== 16'h0 || bus.rdata0 !== 16'h0) $display("FAIL midrst_data got %h %h %h exp 0 0 0", mem_address, mem_data, bus.rdata0); else pass_cnt++;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clock);
            chk_cnt++; if (bus.rvalid0 !== 1'b0) $display("FAIL midrst_no_rvalid k=%0d got %b exp 0", k, bus.rvalid0); else pass_cnt++;
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic e0;
        bus.req0 = 1'b1; bus.addr0 = 6'd10; bus.we0 = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 6'd20; bus.we1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle_all();
            @(negedge clock);
            e0 = (k % 2 == 0) && (k < 4);
            if (k < 4) begin
                chk_cnt++; if (bus.gnt0 !== e0 || bus.gnt1 !== !e0) $display("FAIL cont_gnt k=%0d got %b%b exp %b%b", k, bus.gnt0, bus.gnt1, e0, !e0); else pass_cnt++;
            end
            if (k >= 1 && (k % 2 == 1)) begin
                chk_cnt++; if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.rdata0 !== 16'h1234) $display("FAIL cont_ret0 k=%0d got %b%b %h exp 10 1234", k, bus.rvalid0, bus.rvalid1, bus.rdata0); else pass_cnt++;
            end else if (k >= 1) begin
                chk_cnt++; if (bus.rvalid1 !== 1'b1 || bus.rvalid0 !== 1'b0 || bus.rdata1 !== 16'hFFFF) $display("FAIL cont_ret1 k=%0d got %b%b %h exp 01 ffff", k, bus.rvalid0, bus.rvalid1, bus.rdata1); else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'(k);
            end else begin
                idle_all();
            end
            @(negedge clock);
            if (k < 4) begin
                chk_cnt++; if (bus.gnt1 !== 1'b1) $display("FAIL b2b_gnt1 k=%0d got %b exp 1", k, bus.gnt1); else pass_cnt++;
            end
            if (k >= 1 && k <= 4) begin
                e = 16'h1111 * 16'(k);
                chk_cnt++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== e) $display("FAIL b2b_ret k=%0d got %b %h exp 1 %h", k, bus.rvalid1, bus.rdata1, e); else pass_cnt++;
            end else if (k == 5) begin
                chk_cnt++; if (bus.rvalid1 !== 1'b0) $display("FAIL b2b_end got %b exp 0", bus.rvalid1); else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_lock();
        logic e0;
        bus.req0 = 1'b1; bus.addr0 = 6'd10; bus.we0 = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 6'd20; bus.we1 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            bus.lock0 = (k < 8);
            @(negedge clock);
            e0 = (k < 8) || (k == 9);
            chk_cnt++; if (bus.gnt0 !== e0 || bus.gnt1 !== !e0) $display("FAIL lock_gnt k=%0d got %b%b exp %b%b", k, bus.gnt0, bus.gnt1, e0, !e0); else pass_cnt++;
            next_cycle();
        end
        idle_all();
        next_cycle();
    endtask

    task automatic test_lock_early();
        logic e0;
        bus.req0 = 1'b1; bus.addr0 = 6'd10; bus.we0 = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 6'd20; bus.we1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.lock0 = (k < 2);
            @(negedge clock);
            e0 = (k < 3);
            chk_cnt++; if (bus.gnt0 !== e0 || bus.gnt1 !== !e0) $display("FAIL lock_early_gnt k=%0d got %b%b exp %b%b", k, bus.gnt0, bus.gnt1, e0, !e0); else pass_cnt++;
            next_cycle();
        end
        idle_all();
        next_cycle();
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        clock    = 1'b0;
        resetn   = 1'b0;
        idle_all();
        bus.addr0 = 6'd0; bus.addr1 = 6'd0; bus.wdata0 = 16'h0; bus.wdata1 = 16'h0;
        test_reset();
        preload(6'd10, 16'h1234);
        preload(6'd20, 16'hFFFF);
        preload(6'd0, 16'h1111);
        preload(6'd1, 16'h2222);
        preload(6'd2, 16'h3333);
        preload(6'd3, 16'h4444);
        test_single(6'd5, 16'hAAAA);
        test_single(6'd63, 16'h5A5A);
        test_reset_mid_read();
        test_contention();
        test_back_to_back();
        test_lock();
        test_lock_early();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
Two-requester arbiter that shares the single-port 64x16 synchronous RAM (memoram) between requester 0 (processor) and requester 1 (loader/DMA). It selects one access per clock by round-robin, steers address/data/wren to the RAM, and routes read data back to the owner with a valid strobe. Optional lock gives a requester back-to-back exclusive ownership, bounded by a timeout, for read-modify-write sequences.

Parameters:
AW, 6, RAM address width
DW, 16, RAM data width
RD_LAT, 1, clocks from address sample edge to valid mem_q (legal: 1 or 2)
LOCK_MAX, 8, maximum consecutive locked grants before forced release (>=1)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req0/req1  in  1  access request, held until granted
we0/we1  in  1  1=write, 0=read; valid with req
addr0/addr1  in  AW  word address
wdata0/wdata1  in  DW  write data
lock0/lock1  in  1  keep ownership after this grant
gnt0/gnt1  out  1  combinational; access accepted this cycle
rvalid0/rvalid1  out  1  read data valid this cycle
rdata0/rdata1  out  DW  read data; meaningful only with rvalid
mem_address  out  AW  to RAM address
mem_data  out  DW  to RAM data
mem_wren  out  1  to RAM wren
mem_q  in  DW  from RAM q

Behaviour:
- Reset (resetn=0, async): gnt0/gnt1=0, mem_wren=0, mem_address=0, mem_data=0, rvalid0/1=0, rdata0/1=0, rr_ptr=0 (requester 0 has priority), state=FREE, lock counter=0, read pipeline flushed. Assertion occurring mid-operation drops any in-flight read: no rvalid is produced after reset releases.
- Handshake: transfer occurs in cycle where reqN=1 and gntN=1. Requester may change addr/we/wdata only after its grant. At most one grant per cycle; gnt0&gnt1 never both 1.
- Mux: mem_address/mem_data/mem_wren driven combinationally from the granted requester; with no grant, mem_wren=0 and address/data hold last values (registered copy).
- Round-robin (state FREE): both requesting -> grant requester rr_ptr; single requester -> grant it regardless of rr_ptr. After a grant to N, rr_ptr <= ~N.
- State machine: FREE, LOCKED0, LOCKED1.
  FREE -> LOCKEDn when gntn & lockn.
  LOCKEDn: only requester n may be granted; other side gnt=0. Counter increments per grant to n.
  LOCKEDn -> FREE when a grant to n has lockn=0, or reqn=0 for one cycle, or counter reaches LOCK_MAX (that grant is still served; rr_ptr <= other side so it wins next contention).
- Read return: each granted read pushes owner tag into an RD_LAT-deep shift pipe. When the tag emerges: rvalid_owner=1 for exactly one cycle; rdata_owner = mem_q registered in that cycle. Reads pipeline: one read per cycle, returned in order, no bubbles.
- Writes: no response strobe; write is complete at the grant edge. Read of same address granted the next cycle returns the new data (RAM old-data/new-data behaviour is not relied on within the same cycle since only one access per cycle).
- Simultaneous: req0 and req1 asserted with rr_ptr=1 -> gnt1; req0 waits. A requester holding req with no lock is never starved beyond one grant to the other side.
- Boundary: address 63 and 0 pass unmodified (no wrap logic); LOCK_MAX=1 makes lock a no-op.

Decomposition:
- Shared package mem_arb_pkg: AW/DW defaults, state encoding (FREE=2'd0, LOCKED0=2'd1, LOCKED1=2'd2), owner tag constant values.
- One sub-module natural: rd_tag_pipe (RD_LAT-deep valid+owner shift register with async clear).

Test Plan:
- Reset mid-read: grant read0 @addr 5, assert resetn low before return -> no rvalid0 after release, all outputs 0.
- Single requester: write0 addr 5=16'hAAAA, then read0 addr 5 -> rvalid0 exactly RD_LAT cycles after grant, rdata0=16'hAAAA.
- Contention: req0 and req1 held with reads of addr 10 (16'h1234) and 20 (16'hFFFF) -> grants alternate 0,1,0,1 starting with 0 after reset; each rvalid to correct side with correct data.
- Pipelining: req1 reads addr 0..3 back-to-back -> gnt1 four consecutive cycles, four rvalid1 pulses consecutive, data in order.
- Lock: lock0=1 with both requesting, LOCK_MAX=8 -> eight consecutive gnt0, then gnt1 next cycle, state returns to FREE.
- Lock release early: lock0 dropped on third grant -> next contended cycle grants requester 1.
